prog_mem: RTL and testbench
===========================

PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8: address width; depth is 2**ADDR_W words.
REQ-002 The block SHALL have parameter WORD_W, default 16: instruction width; legal values are multiples of 8 and at least 8; BYTES = WORD_W/8.
REQ-003 The block SHALL have port CLK, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port FETCH, input, 1 bit: fetch request.
REQ-006 The block SHALL have port ADDRESS, input, ADDR_W bits: fetch address.
REQ-007 The block SHALL have port DATA, output, WORD_W bits: fetched instruction, registered.
REQ-008 The block SHALL have port VALID, output, 1 bit: DATA updated by a fetch this cycle.
REQ-009 The block SHALL have port LOAD_START, input, 1 bit: enter or restart load mode.
REQ-010 The block SHALL have port LOAD_ADDR, input, ADDR_W bits: first word address of the load.
REQ-011 The block SHALL have port LOAD_STB, input, 1 bit: LOAD_BYTE valid this cycle.
REQ-012 The block SHALL have port LOAD_BYTE, input, 8 bits: program byte, most significant byte of each word first.
REQ-013 The block SHALL have port LOAD_END, input, 1 bit: leave load mode.
REQ-014 The block SHALL have port BUSY, output, 1 bit: high while in LOAD.
REQ-015 The block SHALL have port LOAD_PTR, output, ADDR_W bits: next word address to be written.
REQ-016 The block SHALL have port PARITY_ERR, output, 1 bit: parity mismatch on the current fetch.

Function
REQ-017 The block SHALL implement a two-state FSM with states IDLE and LOAD; BUSY SHALL be high exactly when in LOAD.
REQ-018 In IDLE, FETCH=1 at edge N SHALL give DATA=CODE[ADDRESS] and VALID=1 after edge N (1-cycle latency); VALID SHALL fall after the next edge unless FETCH is held high.
REQ-019 When no fetch completes, DATA SHALL hold its last value.
REQ-020 LOAD_START=1 SHALL move the FSM to LOAD, set LOAD_PTR=LOAD_ADDR and clear the byte counter and assembly register.
REQ-021 If LOAD_START=1 while already in LOAD, any partial word SHALL be discarded and LOAD_PTR reloaded.
REQ-022 If LOAD_START=1 and FETCH=1 in the same IDLE cycle, the load SHALL win: the fetch is dropped and VALID stays 0.
REQ-023 In LOAD, each LOAD_STB SHALL shift LOAD_BYTE into the assembly register, MSB-first.
REQ-024 The BYTES-th strobe SHALL write the assembled word to CODE[LOAD_PTR] at that edge, increment LOAD_PTR modulo 2**ADDR_W (255 wraps to 0 at the default width), and clear the byte counter.
REQ-025 In LOAD, FETCH SHALL be ignored and VALID SHALL be 0.
REQ-026 LOAD_END=1 SHALL return the FSM to IDLE and discard any incomplete word.
REQ-027 If LOAD_END=1 coincides with the word-completing LOAD_STB, the word SHALL be written and the FSM SHALL then return to IDLE.
REQ-028 LOAD_END in IDLE SHALL have no effect; LOAD_STB in IDLE SHALL be ignored.
REQ-029 LOAD_START and LOAD_END in the same cycle SHALL resolve in favour of LOAD_START.

Reset
REQ-030 RESET_N=0 SHALL immediately force: FSM=IDLE, DATA=0, VALID=0, BUSY=0, LOAD_PTR=0, PARITY_ERR=0, byte counter=0.
REQ-031 Memory contents SHALL be initialised to all-zero at time zero and SHALL NOT be altered by reset.
REQ-032 A reset asserted mid-load SHALL abort the load and discard the partial word; words already written SHALL persist.

Configuration
REQ-033 With PROG_MEM_PARITY_EN defined, each stored word SHALL carry an even-parity bit computed at write time; a fetch whose recomputed parity mismatches SHALL assert PARITY_ERR together with VALID for that cycle.
REQ-034 Without PROG_MEM_PARITY_EN, no parity storage SHALL exist and PARITY_ERR SHALL be constant 0.

Verification (ADDR_W=8, WORD_W=16)
REQ-035 Reset then FETCH=1 at ADDRESS=8'h10 -> next cycle DATA=16'h0000, VALID=1.
REQ-036 LOAD_START with LOAD_ADDR=8'h20; bytes 8'hA5, 8'h3C, 8'h12, 8'h34; LOAD_END; FETCH at 8'h20 then 8'h21 -> DATA=16'hA53C then 16'h1234; LOAD_PTR=8'h22 after the load.
REQ-037 LOAD_ADDR=8'hFF; four bytes 8'h11, 8'h22, 8'h33, 8'h44 -> CODE[8'hFF]=16'h1122, CODE[8'h00]=16'h3344, LOAD_PTR=8'h01.
REQ-038 Byte 8'h77 then LOAD_END -> no write, LOAD_PTR unchanged; FETCH issued during LOAD -> VALID stays 0.
REQ-039 RESET_N pulsed low mid-load after one byte -> BUSY=0, LOAD_PTR=0; previously written words read back intact.
REQ-040 With PROG_MEM_PARITY_EN defined, force one stored bit flipped, then fetch that word -> PARITY_ERR=1 with VALID=1; a clean word -> PARITY_ERR=0.

Source files
------------

// File: rtl/prog_mem.sv
// Byte-loadable program memory with a registered fetch port.
// Optional per-word even parity: define PROG_MEM_PARITY_EN.
module prog_mem #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned WORD_W = 16
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              FETCH,
    input  logic [ADDR_W-1:0] ADDRESS,
    output logic [WORD_W-1:0] DATA,
    output logic              VALID,
    input  logic              LOAD_START,
    input  logic [ADDR_W-1:0] LOAD_ADDR,
    input  logic              LOAD_STB,
    input  logic [7:0]        LOAD_BYTE,
    input  logic              LOAD_END,
    output logic              BUSY,
    output logic [ADDR_W-1:0] LOAD_PTR,
    output logic              PARITY_ERR
);

    localparam int unsigned BYTES = WORD_W / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
`ifdef PROG_MEM_PARITY_EN
    localparam int unsigned MEM_W = WORD_W + 1;
`else
    localparam int unsigned MEM_W = WORD_W;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  byte_cnt;
    logic [WORD_W-1:0] asm_q;
    logic [MEM_W-1:0]  code [DEPTH] = '{default: '0};

    logic [WORD_W-1:0] wdata_c;
    logic [MEM_W-1:0]  mem_wdata_c;
    logic [MEM_W-1:0]  rd_c;
    logic              we_c;

    // Incoming byte shifted in below the bytes already collected (MSB first).
    assign wdata_c = WORD_W'({asm_q, LOAD_BYTE});
    assign we_c    = (state == LOAD) && LOAD_STB && !LOAD_START
                     && (byte_cnt == CNT_W'(BYTES - 1));
    assign rd_c    = code[ADDRESS];

`ifdef PROG_MEM_PARITY_EN
    assign mem_wdata_c = {^wdata_c, wdata_c};
`else
    assign mem_wdata_c = wdata_c;
    assign PARITY_ERR  = 1'b0;
`endif

    // Storage is not reset so a reset mid-load keeps earlier words.
    always_ff @(posedge CLK) begin
        if (we_c) begin
            code[LOAD_PTR] <= mem_wdata_c;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            DATA     <= '0;
            VALID    <= 1'b0;
            BUSY     <= 1'b0;
            LOAD_PTR <= '0;
            byte_cnt <= '0;
            asm_q    <= '0;
`ifdef PROG_MEM_PARITY_EN
            PARITY_ERR <= 1'b0;
`endif
        end else begin
            VALID <= 1'b0;
`ifdef PROG_MEM_PARITY_EN
            PARITY_ERR <= 1'b0;
`endif
            if (state == IDLE) begin
                // A load request takes priority over a same-cycle fetch.
                if (LOAD_START) begin
                    state    <= LOAD;
                    BUSY     <= 1'b1;
                    LOAD_PTR <= LOAD_ADDR;
                    byte_cnt <= '0;
                    asm_q    <= '0;
                end else if (FETCH) begin
                    DATA  <= rd_c[WORD_W-1:0];
                    VALID <= 1'b1;
`ifdef PROG_MEM_PARITY_EN
                    PARITY_ERR <= ^rd_c;
`endif
                end
            end else begin
                if (LOAD_START) begin
                    LOAD_PTR <= LOAD_ADDR;
                    byte_cnt <= '0;
                    asm_q    <= '0;
                end else begin
                    if (LOAD_STB) begin
                        if (we_c) begin
                            LOAD_PTR <= LOAD_PTR + ADDR_W'(1);
                            byte_cnt <= '0;
                            asm_q    <= '0;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                            asm_q    <= wdata_c;
                        end
                    end
                    // Leaving load drops any partial word; a completing word is already written.
                    if (LOAD_END) begin
                        state    <= IDLE;
                        BUSY     <= 1'b0;
                        byte_cnt <= '0;
                        asm_q    <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_mem.sv
// Directed self-checking bench for prog_mem (ADDR_W=8, WORD_W=16).
module tb_prog_mem;

    logic        CLK;
    logic        RESET_N;
    logic        FETCH;
    logic [7:0]  ADDRESS;
    logic [15:0] DATA;
    logic        VALID;
    logic        LOAD_START;
    logic [7:0]  LOAD_ADDR;
    logic        LOAD_STB;
    logic [7:0]  LOAD_BYTE;
    logic        LOAD_END;
    logic        BUSY;
    logic [7:0]  LOAD_PTR;
    logic        PARITY_ERR;

    int n_cmp = 0;
    int n_bad = 0;

    prog_mem #(.ADDR_W(8), .WORD_W(16)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .FETCH      (FETCH),
        .ADDRESS    (ADDRESS),
        .DATA       (DATA),
        .VALID      (VALID),
        .LOAD_START (LOAD_START),
        .LOAD_ADDR  (LOAD_ADDR),
        .LOAD_STB   (LOAD_STB),
        .LOAD_BYTE  (LOAD_BYTE),
        .LOAD_END   (LOAD_END),
        .BUSY       (BUSY),
        .LOAD_PTR   (LOAD_PTR),
        .PARITY_ERR (PARITY_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_load(input logic [7:0] a);
        LOAD_START = 1'b1;
        LOAD_ADDR  = a;
        tick();
        LOAD_START = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic with_end);
        LOAD_STB  = 1'b1;
        LOAD_BYTE = b;
        LOAD_END  = with_end;
        tick();
        LOAD_STB  = 1'b0;
        LOAD_END  = 1'b0;
    endtask

    task automatic end_load();
        LOAD_END = 1'b1;
        tick();
        LOAD_END = 1'b0;
    endtask

    task automatic do_fetch(input logic [7:0] a);
        FETCH   = 1'b1;
        ADDRESS = a;
        tick();
        FETCH   = 1'b0;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        #1;
        n_cmp++; if (DATA !== 16'h0000) begin n_bad++; $display("FAIL reset_data got %h exp 0000", DATA); end
        n_cmp++; if (VALID !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", VALID); end
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", BUSY); end
        n_cmp++; if (LOAD_PTR !== 8'h00) begin n_bad++; $display("FAIL reset_ptr got %h exp 00", LOAD_PTR); end
        n_cmp++; if (PARITY_ERR !== 1'b0) begin n_bad++; $display("FAIL reset_perr got %b exp 0", PARITY_ERR); end
        tick();
        tick();
        RESET_N = 1'b1;
        tick();
    endtask

    task automatic test_fetch_zero();
        do_fetch(8'h10);
        n_cmp++; if (DATA !== 16'h0000) begin n_bad++; $display("FAIL fetch0_data got %h exp 0000", DATA); end
        n_cmp++; if (VALID !== 1'b1) begin n_bad++; $display("FAIL fetch0_valid got %b exp 1", VALID); end
        tick();
        n_cmp++; if (VALID !== 1'b0) begin n_bad++; $display("FAIL fetch0_valid_fall got %b exp 0", VALID); end
    endtask

    task automatic test_load_basic();
        start_load(8'h20);
        n_cmp++; if (BUSY !== 1'b1) begin n_bad++; $display("FAIL load_busy got %b exp 1", BUSY); end
        n_cmp++; if (LOAD_PTR !== 8'h20) begin n_bad++; $display("FAIL load_ptr_start got %h exp 20", LOAD_PTR); end
        send_byte(8'hA5, 1'b0);
        n_cmp++; if (LOAD_PTR !== 8'h20) begin n_bad++; $display("FAIL load_ptr_half got %h exp 20", LOAD_PTR); end
        send_byte(8'h3C, 1'b0);
        n_cmp++; if (LOAD_PTR !== 8'h21) begin n_bad++; $display("FAIL load_ptr_w1 got %h exp 21", LOAD_PTR); end
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        end_load();
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL load_end_busy got %b exp 0", BUSY); end
        n_cmp++; if (LOAD_PTR !== 8'h22) begin n_bad++; $display("FAIL load_ptr_end got %h exp 22", LOAD_PTR); end
    endtask

    task automatic test_back_to_back();
        FETCH   = 1'b1;
        ADDRESS = 8'h20;
        tick();
        n_cmp++; if (DATA !== 16'hA53C || VALID !== 1'b1) begin n_bad++; $display("FAIL b2b_first got %h/%b exp a53c/1", DATA, VALID); end
        ADDRESS = 8'h21;
        tick();
        n_cmp++; if (DATA !== 16'h1234 || VALID !== 1'b1) begin n_bad++; $display("FAIL b2b_second got %h/%b exp 1234/1", DATA, VALID); end
        FETCH = 1'b0;
        tick();
        n_cmp++; if (DATA !== 16'h1234 || VALID !== 1'b0) begin n_bad++; $display("FAIL b2b_hold got %h/%b exp 1234/0", DATA, VALID); end
    endtask

    task automatic test_wrap();
        start_load(8'hFF);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        n_cmp++; if (LOAD_PTR !== 8'h00) begin n_bad++; $display("FAIL wrap_ptr got %h exp 00", LOAD_PTR); end
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        n_cmp++; if (LOAD_PTR !== 8'h01 || BUSY !== 1'b0) begin n_bad++; $display("FAIL wrap_end got %h/%b exp 01/0", LOAD_PTR, BUSY); end
        do_fetch(8'hFF);
        n_cmp++; if (DATA !== 16'h1122) begin n_bad++; $display("FAIL wrap_ff got %h exp 1122", DATA); end
        do_fetch(8'h00);
        n_cmp++; if (DATA !== 16'h3344) begin n_bad++; $display("FAIL wrap_00 got %h exp 3344", DATA); end
    endtask

    task automatic test_partial();
        start_load(8'h30);
        send_byte(8'h77, 1'b0);
        do_fetch(8'h20);
        n_cmp++; if (VALID !== 1'b0 || DATA !== 16'h3344) begin n_bad++; $display("FAIL load_fetch got %h/%b exp 3344/0", DATA, VALID); end
        end_load();
        n_cmp++; if (LOAD_PTR !== 8'h30 || BUSY !== 1'b0) begin n_bad++; $display("FAIL partial_ptr got %h/%b exp 30/0", LOAD_PTR, BUSY); end
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        n_cmp++; if (LOAD_PTR !== 8'h30 || BUSY !== 1'b0) begin n_bad++; $display("FAIL idle_stb got %h/%b exp 30/0", LOAD_PTR, BUSY); end
        do_fetch(8'h30);
        n_cmp++; if (DATA !== 16'h0000 || VALID !== 1'b1) begin n_bad++; $display("FAIL partial_mem got %h/%b exp 0000/1", DATA, VALID); end
    endtask

    task automatic test_priority();
        FETCH      = 1'b1;
        ADDRESS    = 8'h20;
        LOAD_START = 1'b1;
        LOAD_ADDR  = 8'h38;
        tick();
        FETCH      = 1'b0;
        LOAD_START = 1'b0;
        n_cmp++; if (VALID !== 1'b0 || BUSY !== 1'b1) begin n_bad++; $display("FAIL start_vs_fetch got %b/%b exp 0/1", VALID, BUSY); end
        send_byte(8'hAA, 1'b0);
        LOAD_START = 1'b1;
        LOAD_END   = 1'b1;
        LOAD_ADDR  = 8'h40;
        tick();
        LOAD_START = 1'b0;
        LOAD_END   = 1'b0;
        n_cmp++; if (BUSY !== 1'b1 || LOAD_PTR !== 8'h40) begin n_bad++; $display("FAIL start_vs_end got %b/%h exp 1/40", BUSY, LOAD_PTR); end
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        end_load();
        do_fetch(8'h40);
        n_cmp++; if (DATA !== 16'hBBCC) begin n_bad++; $display("FAIL restart_word got %h exp bbcc", DATA); end
        do_fetch(8'h38);
        n_cmp++; if (DATA !== 16'h0000) begin n_bad++; $display("FAIL restart_old got %h exp 0000", DATA); end
    endtask

    task automatic test_reset_midload();
        start_load(8'h50);
        send_byte(8'h99, 1'b0);
        #2;
        RESET_N = 1'b0;
        #1;
        n_cmp++; if (BUSY !== 1'b0 || LOAD_PTR !== 8'h00) begin n_bad++; $display("FAIL midrst_state got %b/%h exp 0/00", BUSY, LOAD_PTR); end
        tick();
        RESET_N = 1'b1;
        tick();
        do_fetch(8'h20);
        n_cmp++; if (DATA !== 16'hA53C) begin n_bad++; $display("FAIL midrst_keep20 got %h exp a53c", DATA); end
        do_fetch(8'hFF);
        n_cmp++; if (DATA !== 16'h1122) begin n_bad++; $display("FAIL midrst_keepff got %h exp 1122", DATA); end
        do_fetch(8'h50);
        n_cmp++; if (DATA !== 16'h0000) begin n_bad++; $display("FAIL midrst_partial got %h exp 0000", DATA); end
    endtask

    task automatic test_parity();
`ifdef PROG_MEM_PARITY_EN
        dut.code[8'h21][0] = ~dut.code[8'h21][0];
        do_fetch(8'h21);
        n_cmp++; if (PARITY_ERR !== 1'b1 || VALID !== 1'b1) begin n_bad++; $display("FAIL parity_bad got %b/%b exp 1/1", PARITY_ERR, VALID); end
        do_fetch(8'h20);
        n_cmp++; if (PARITY_ERR !== 1'b0 || VALID !== 1'b1) begin n_bad++; $display("FAIL parity_clean got %b/%b exp 0/1", PARITY_ERR, VALID); end
`else
        do_fetch(8'h21);
        n_cmp++; if (PARITY_ERR !== 1'b0 || VALID !== 1'b1) begin n_bad++; $display("FAIL parity_off got %b/%b exp 0/1", PARITY_ERR, VALID); end
`endif
    endtask

    initial begin
        RESET_N    = 1'b1;
        FETCH      = 1'b0;
        ADDRESS    = '0;
        LOAD_START = 1'b0;
        LOAD_ADDR  = '0;
        LOAD_STB   = 1'b0;
        LOAD_BYTE  = '0;
        LOAD_END   = 1'b0;
        #3;
        test_reset();
        test_fetch_zero();
        test_load_basic();
        test_back_to_back();
        test_wrap();
        test_partial();
        test_priority();
        test_reset_midload();
        test_parity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
